// File: rtl/test_pkg.sv
// Shared package for the producer/receiver pair: common widths, default depth and
// the byte transform helpers used on each side of the link.
package test_pkg;

    localparam int PKG_WIDTH        = 16;
    localparam int RX_DEFAULT_DEPTH = 4;

    // Producer-side transform: value + 1 modulo 256.
    function automatic logic [7:0] increment(input logic [7:0] value);
        return value + 8'd1;
    endfunction

    // Receiver-side inverse: value - 1 modulo 256, so 8'h00 maps to 8'hFF.
    function automatic logic [7:0] decrement(input logic [7:0] value);
        return value - 8'd1;
    endfunction

endpackage

// File: rtl/packet_rx_fifo.sv
// First-word fall-through FIFO for packet_rx_decoder. Pointers carry one extra
// wrap bit so that full and empty are distinguishable without a separate counter.
module packet_rx_fifo
    import test_pkg::*;
#(
    parameter int DEPTH = RX_DEFAULT_DEPTH,
    parameter int DW    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [DW-1:0]            wdata_i,
    output logic [DW-1:0]            rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [DW-1:0] mem_q [DEPTH];

    // Next-pointer logic; flush overrides any push or pop in the same cycle.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush_i) begin
            wr_d = {PW{1'b0}};
            rd_d = {PW{1'b0}};
        end else begin
            if (push_i) begin
                wr_d = wr_q + PW'(1);
            end else begin
                wr_d = wr_q;
            end
            if (pop_i) begin
                rd_d = rd_q + PW'(1);
            end else begin
                rd_d = rd_q;
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= {PW{1'b0}};
            rd_q <= {PW{1'b0}};
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage write; contents are not reset.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = (wr_q == rd_q);
    assign level_o = wr_q - rd_q;
    assign rdata_o = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/packet_rx_decoder.sv
// Receive-side decoder: undoes the producer's +1 transform and buffers bytes for a
// valid/ready consumer. Define PKT_RX_DROP_CNT_EN to add the saturating drop_count output.
module packet_rx_decoder
    import test_pkg::*;
#(
    parameter int WIDTH = PKG_WIDTH,
    parameter int DEPTH = RX_DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    input  logic                     out_ready,
    input  logic                     flush,
    input  logic                     clr_ovf,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level,
    output logic [WIDTH-1:0]         pkt_count
`ifdef PKT_RX_DROP_CNT_EN
    ,
    output logic [7:0]               drop_count
`endif
);

    logic       full_s;
    logic       empty_s;
    logic       push_s;
    logic       pop_s;
    logic       drop_s;
    logic [7:0] head_s;
    logic       overflow_q, overflow_d;
    logic [WIDTH-1:0] pkt_count_q, pkt_count_d;

    // A flush swallows the concurrent beat: it is neither stored, counted nor flagged.
    assign pop_s  = !empty_s && out_ready && !flush;
    assign push_s = enable && in_valid && (!full_s || pop_s) && !flush;
    assign drop_s = enable && in_valid && full_s && !pop_s && !flush;

    packet_rx_fifo #(
        .DEPTH (DEPTH),
        .DW    (8)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .flush_i (flush),
        .wdata_i (decrement(in_data)),
        .rdata_o (head_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .level_o (level)
    );

    // Sticky overflow (drop beats clear) and wrapping accepted-beat counter.
    always_comb begin
        overflow_d  = overflow_q;
        pkt_count_d = pkt_count_q;
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        if (push_s) begin
            pkt_count_d = pkt_count_q + WIDTH'(1);
        end else begin
            pkt_count_d = pkt_count_q;
        end
    end

    // Status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            pkt_count_q <= {WIDTH{1'b0}};
        end else begin
            overflow_q  <= overflow_d;
            pkt_count_q <= pkt_count_d;
        end
    end

`ifdef PKT_RX_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    // Saturating drop counter; a drop coinciding with clr_ovf restarts it at one.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clr_ovf) begin
            drop_cnt_d = drop_s ? 8'd1 : 8'd0;
        end else if (drop_s && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

    assign out_valid = !empty_s;
    assign out_data  = empty_s ? 8'h00 : head_s;
    assign overflow  = overflow_q;
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_packet_rx_decoder.sv
// Scoreboard bench for packet_rx_decoder: directed test-plan steps followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_packet_rx_decoder;
    import test_pkg::*;

    localparam int DEPTH = 4;
    localparam int WIDTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       flush = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       overflow;
    logic [$clog2(DEPTH):0] level;
    logic [WIDTH-1:0] pkt_count;
`ifdef PKT_RX_DROP_CNT_EN
    logic [7:0] drop_count;
`endif

    packet_rx_decoder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .flush     (flush),
        .clr_ovf   (clr_ovf),
        .out_data  (out_data),
        .out_valid (out_valid),
        .overflow  (overflow),
        .level     (level),
        .pkt_count (pkt_count)
`ifdef PKT_RX_DROP_CNT_EN
        ,
        .drop_count(drop_count)
`endif
    );

    int compared = 0;
    int mismatched = 0;

    // Reference model: the queue holds the decoded bytes the DUT should be buffering.
    logic [7:0] exp_q[$];
    int unsigned m_cnt = 0;
    bit m_ovf = 1'b0;
    int m_dc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        chk("level", 32'(level), 32'(exp_q.size()));
        chk("out_valid", 32'(out_valid), (exp_q.size() > 0) ? 32'd1 : 32'd0);
        chk("pkt_count", 32'(pkt_count), m_cnt % 65536);
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (exp_q.size() > 0) chk("head_data", 32'(out_data), 32'(exp_q[0]));
        else chk("idle_data", 32'(out_data), 32'd0);
`ifdef PKT_RX_DROP_CNT_EN
        chk("drop_count", 32'(drop_count), 32'(m_dc));
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        out_ready = 1'b0; flush = 1'b0; clr_ovf = 1'b0;
        exp_q.delete(); m_cnt = 0; m_ovf = 1'b0; m_dc = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        check_state();
    endtask

    // One cycle of stimulus; the model decides the outcome from occupancy alone.
    task automatic drive(input bit en, input bit v, input logic [7:0] d,
                         input bit rdy, input bit fl, input bit clr);
        int  sz;
        bit  popping, drop;
        enable = en; in_valid = v; in_data = d; out_ready = rdy; flush = fl; clr_ovf = clr;
        sz = exp_q.size();
        popping = (sz > 0) && rdy && !fl;
        drop = 1'b0;
        if (fl) begin
            exp_q.delete();
        end else if (en && v) begin
            if (sz < DEPTH || popping) begin
                exp_q.push_back(8'((int'(d) + 255) % 256));
                m_cnt++;
            end else begin
                drop = 1'b1;
            end
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (clr) m_dc = drop ? 1 : 0;
        else if (drop && m_dc < 255) m_dc++;
        @(posedge clk); #1;
        check_state();
    endtask

    // Monitor: every handshake consumes the oldest expected byte.
    always @(negedge clk) begin
        if (!reset && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL scoreboard: unexpected output 0x%0h, expected none", out_data);
            end else begin
                chk("scoreboard", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int unsigned saved_cnt;
        do_reset();

        drive(1'b1, 1'b1, 8'h10, 1'b1, 1'b0, 1'b0);
        chk("tp_first_data", 32'(out_data), 32'h0F);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("tp_first_cnt", 32'(pkt_count), 32'd1);
        chk("tp_first_level", 32'(level), 32'd0);

        drive(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("tp_wrap_00", 32'(out_data), 32'hFF);
        drive(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        chk("tp_wrap_ff", 32'(out_data), 32'hFE);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        for (int i = 1; i <= 6; i++) drive(1'b1, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        chk("tp_ovf_level", 32'(level), 32'd4);
        chk("tp_ovf_flag", 32'(overflow), 32'd1);
        chk("tp_ovf_cnt", 32'(pkt_count), 32'd7);
        chk("tp_ovf_head", 32'(out_data), 32'h00);
`ifdef PKT_RX_DROP_CNT_EN
        chk("tp_ovf_drops", 32'(drop_count), 32'd2);
`endif

        drive(1'b1, 1'b1, 8'h20, 1'b1, 1'b0, 1'b0);
        chk("tp_fullpp_level", 32'(level), 32'd4);
        chk("tp_fullpp_cnt", 32'(pkt_count), 32'd8);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
        chk("tp_flush_pre", 32'(level), 32'd3);
        saved_cnt = m_cnt;
        drive(1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
        chk("tp_flush_level", 32'(level), 32'd0);
        chk("tp_flush_valid", 32'(out_valid), 32'd0);
        chk("tp_flush_cnt", 32'(pkt_count), saved_cnt);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 8'h60 + 8'(i), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 8'h70, 1'b0, 1'b0, 1'b1);
        chk("tp_setwins", 32'(overflow), 32'd1);
`ifdef PKT_RX_DROP_CNT_EN
        chk("tp_setwins_drops", 32'(drop_count), 32'd1);
`endif

        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("tp_mid_level", 32'(level), 32'd2);
        do_reset();
        chk("tp_rst_valid", 32'(out_valid), 32'd0);
        chk("tp_rst_cnt", 32'(pkt_count), 32'd0);
        chk("tp_rst_ovf", 32'(overflow), 32'd0);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 7) != 0, $urandom_range(0, 9) < 6, 8'($urandom),
                      $urandom_range(0, 1) == 1, $urandom_range(0, 24) == 0,
                      $urandom_range(0, 15) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
